alu_decode_stage: RTL and testbench

//  Producer side of the ALU control interface: registered decode stage turning RV32I ALU-class

---
 rtl/alu_pkg.sv | 52 +++++
 rtl/alu_imm_gen.sv | 21 ++
 rtl/alu_decode_stage.sv | 150 +++++++++++++++
 tb/tb_alu_decode_stage.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU encodings: funct3 codes, major opcodes, operand selects, decode bundle.
// Latency: none (package only).
// Backpressure: not applicable.
package alu_pkg;

    // ALU function codes, identical to the ISA funct3 field
    localparam logic [2:0] ALU_ADD_SUB = 3'b000;
    localparam logic [2:0] ALU_SLL     = 3'b001;
    localparam logic [2:0] ALU_SLT     = 3'b010;
    localparam logic [2:0] ALU_SLTU    = 3'b011;
    localparam logic [2:0] ALU_XOR     = 3'b100;
    localparam logic [2:0] ALU_SRL_SRA = 3'b101;
    localparam logic [2:0] ALU_OR      = 3'b110;
    localparam logic [2:0] ALU_AND_CLR = 3'b111;

    // Major opcodes handled by the ALU decode stage
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // funct7 / imm[11:5] patterns
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Operand select encodings
    localparam logic [1:0] OP1_RS1  = 2'b00;
    localparam logic [1:0] OP1_PC   = 2'b01;
    localparam logic [1:0] OP1_ZERO = 2'b10;
    localparam logic       OP2_RS2  = 1'b0;
    localparam logic       OP2_IMM  = 1'b1;

    // Everything the execute stage needs from one decoded instruction
    typedef struct packed {
        logic [2:0]  func;
        logic        func_sel;
        logic [1:0]  op1_sel;
        logic        op2_sel;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_we;
        logic        illegal;
    } dec_t;

    // x0 is never written, and a trapping instruction never writes back
    function automatic logic rd_write_en(input logic illegal, input logic [4:0] rd);
        return !illegal && (rd != 5'd0);
    endfunction

endpackage

// File: rtl/alu_imm_gen.sv
// Immediate extraction: sign-extended I-imm for OP-IMM, U-imm for LUI/AUIPC, else zero.
// Latency: combinational.
// Backpressure: none, pure function of the instruction word.
module alu_imm_gen
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    // Pick the immediate format from the major opcode
    always_comb begin
        imm = 32'd0;
        case (instr[6:0])
            OPC_OP_IMM:         imm = {{20{instr[31]}}, instr[31:20]};
            OPC_LUI, OPC_AUIPC: imm = {instr[31:12], 12'd0};
            default:            imm = 32'd0;
        endcase
    end

endmodule

// File: rtl/alu_decode_stage.sv
// RV32I ALU-class decode stage (OP, OP-IMM, LUI, AUIPC); optional ANDN via ALU_ANDN_EN.
// Latency: 1 cycle, full throughput while out_ready is high.
// Backpressure: in_ready = (!out_valid | out_ready) & !flush; held outputs are stable while stalled.
module alu_decode_stage
    import alu_pkg::*;
#(
    parameter int PC_WIDTH  = 32,
    parameter bit FLUSH_NOP = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    input  logic [PC_WIDTH-1:0] in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PC_WIDTH-1:0] out_pc,
    output logic [2:0]          alu_func,
    output logic                alu_func_sel,
    output logic [1:0]          op1_sel,
    output logic                op2_sel,
    output logic [31:0]         imm,
    output logic [4:0]          rs1,
    output logic [4:0]          rs2,
    output logic [4:0]          rd,
    output logic                rd_we,
    output logic                illegal
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_w;
    logic        bad;
    logic        xfer;
    dec_t        dec;
    dec_t        dec_q;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    alu_imm_gen u_imm_gen (
        .instr (in_instr),
        .imm   (imm_w)
    );

    // A flush blocks the input so a redirect never lets a wrong-path instruction in
    assign in_ready = (!out_valid || out_ready) && !flush;
    assign xfer     = in_valid && in_ready;

    // Combinational decode of the incoming instruction word
    always_comb begin
        bad          = 1'b0;
        dec          = '0;
        dec.rs1      = in_instr[19:15];
        dec.rs2      = in_instr[24:20];
        dec.rd       = in_instr[11:7];
        dec.imm      = imm_w;
        dec.op1_sel  = OP1_RS1;
        dec.op2_sel  = OP2_RS2;
        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    dec.func = funct3;
                end else if (funct7 == F7_ALT &&
                             (funct3 == ALU_ADD_SUB || funct3 == ALU_SRL_SRA)) begin
                    dec.func     = funct3;
                    dec.func_sel = 1'b1;
                end
`ifdef ALU_ANDN_EN
                else if (funct7 == F7_ALT && funct3 == ALU_AND_CLR) begin
                    dec.func     = funct3;
                    dec.func_sel = 1'b1;
                end
`endif
                else begin
                    bad = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                dec.op2_sel = OP2_IMM;
                dec.func    = funct3;
                if (funct3 == ALU_SLL && funct7 != F7_BASE) begin
                    bad = 1'b1;
                end else if (funct3 == ALU_SRL_SRA) begin
                    if (funct7 == F7_ALT) begin
                        dec.func_sel = 1'b1;
                    end else if (funct7 != F7_BASE) begin
                        bad = 1'b1;
                    end
                end
            end
            OPC_LUI: begin
                dec.op1_sel = OP1_ZERO;
                dec.op2_sel = OP2_IMM;
            end
            OPC_AUIPC: begin
                dec.op1_sel = OP1_PC;
                dec.op2_sel = OP2_IMM;
            end
            default: bad = 1'b1;
        endcase
        // Compressed / non-32-bit encodings are never ours
        if (in_instr[1:0] != 2'b11) begin
            bad = 1'b1;
        end
        if (bad) begin
            dec.func     = ALU_ADD_SUB;
            dec.func_sel = 1'b0;
        end
        dec.illegal = bad;
        dec.rd_we   = rd_write_en(bad, dec.rd);
    end

    // Output register bank and valid flop; flush beats a simultaneous transfer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_pc    <= '0;
            dec_q     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            if (FLUSH_NOP) begin
                dec_q.rd_we   <= 1'b0;
                dec_q.illegal <= 1'b0;
            end
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_pc    <= in_pc;
            dec_q     <= dec;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign alu_func     = dec_q.func;
    assign alu_func_sel = dec_q.func_sel;
    assign op1_sel      = dec_q.op1_sel;
    assign op2_sel      = dec_q.op2_sel;
    assign imm          = dec_q.imm;
    assign rs1          = dec_q.rs1;
    assign rs2          = dec_q.rs2;
    assign rd           = dec_q.rd;
    assign rd_we        = dec_q.rd_we;
    assign illegal      = dec_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed-vector bench for alu_decode_stage with hand-computed expectations.
// Inputs driven and outputs sampled on the falling edge; DUT registers on the rising edge.
// No handshake waits: every step is a fixed number of cycles.
module tb_alu_decode_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [2:0]  alu_func;
    logic        alu_func_sel;
    logic [1:0]  op1_sel;
    logic        op2_sel;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_decode_stage #(.PC_WIDTH(32), .FLUSH_NOP(1'b1)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .alu_func     (alu_func),
        .alu_func_sel (alu_func_sel),
        .op1_sel      (op1_sel),
        .op2_sel      (op2_sel),
        .imm          (imm),
        .rs1          (rs1),
        .rs2          (rs2),
        .rd           (rd),
        .rd_we        (rd_we),
        .illegal      (illegal)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present one instruction; the transfer happens on the next rising edge
    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
    endtask

    task automatic exp_dec(input string tag, input logic [2:0] f, input logic s,
                           input logic [1:0] o1, input logic o2, input logic [4:0] d,
                           input logic we, input logic ill);
        check({tag, ".valid"}, out_valid, 1'b1);
        check({tag, ".func"},  alu_func, f);
        check({tag, ".sel"},   alu_func_sel, s);
        check({tag, ".op1"},   op1_sel, o1);
        check({tag, ".op2"},   op2_sel, o2);
        check({tag, ".rd"},    rd, d);
        check({tag, ".rd_we"}, rd_we, we);
        check({tag, ".ill"},   illegal, ill);
    endtask

    // Single instruction through with out_ready high, then let it drain
    task automatic one(input string tag, input logic [31:0] instr, input logic [2:0] f,
                       input logic s, input logic [1:0] o1, input logic o2,
                       input logic [4:0] d, input logic we, input logic ill);
        send(instr, 32'h400);
        cyc();
        in_valid = 1'b0;
        exp_dec(tag, f, s, o1, o2, d, we, ill);
        cyc();
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'd0;
        in_pc     = 32'd0;
        out_ready = 1'b1;
        repeat (3) cyc();
        check("rst.valid", out_valid, 1'b0);
        check("rst.pc",    out_pc, 32'd0);
        check("rst.imm",   imm, 32'd0);
        check("rst.op1",   op1_sel, 2'b00);
        check("rst.op2",   op2_sel, 1'b0);
        check("rst.rd_we", rd_we, 1'b0);
        check("rst.ill",   illegal, 1'b0);
        reset_n = 1'b1;
        cyc();
        check("rst.in_ready", in_ready, 1'b1);

        // ADD x3,x1,x2
        send(32'h002081B3, 32'h100);
        cyc();
        in_valid = 1'b0;
        exp_dec("add", 3'b000, 1'b0, 2'b00, 1'b0, 5'd3, 1'b1, 1'b0);
        check("add.rs1", rs1, 5'd1);
        check("add.rs2", rs2, 5'd2);
        check("add.pc",  out_pc, 32'h100);
        cyc();
        check("add.drain", out_valid, 1'b0);

        // SUB then SRAI back-to-back
        send(32'h402081B3, 32'h104);
        cyc();
        exp_dec("sub", 3'b000, 1'b1, 2'b00, 1'b0, 5'd3, 1'b1, 1'b0);
        check("sub.in_ready", in_ready, 1'b1);
        send(32'h40335293, 32'h108);
        cyc();
        in_valid = 1'b0;
        exp_dec("srai", 3'b101, 1'b1, 2'b00, 1'b1, 5'd5, 1'b1, 1'b0);
        check("srai.imm", imm, 32'h00000403);
        check("srai.rs1", rs1, 5'd6);
        check("srai.pc",  out_pc, 32'h108);
        cyc();

        // LUI / AUIPC, rd=0 variant, negative I-immediate
        one("lui", 32'h123450B7, 3'b000, 1'b0, 2'b10, 1'b1, 5'd1, 1'b1, 1'b0);
        send(32'h123450B7, 32'h10C);
        cyc();
        in_valid = 1'b0;
        check("lui.imm", imm, 32'h12345000);
        cyc();
        one("lui0",  32'h12345037, 3'b000, 1'b0, 2'b10, 1'b1, 5'd0, 1'b0, 1'b0);
        one("auipc", 32'h12345097, 3'b000, 1'b0, 2'b01, 1'b1, 5'd1, 1'b1, 1'b0);
        send(32'hFFF00093, 32'h110);
        cyc();
        in_valid = 1'b0;
        exp_dec("addi", 3'b000, 1'b0, 2'b00, 1'b1, 5'd1, 1'b1, 1'b0);
        check("addi.imm", imm, 32'hFFFFFFFF);
        cyc();

        // Illegal encodings
`ifdef ALU_ANDN_EN
        one("andn", 32'h4020F1B3, 3'b111, 1'b1, 2'b00, 1'b0, 5'd3, 1'b1, 1'b0);
`else
        one("andn", 32'h4020F1B3, 3'b000, 1'b0, 2'b00, 1'b0, 5'd3, 1'b0, 1'b1);
`endif
        one("slli_bad", 32'h02109093, 3'b000, 1'b0, 2'b00, 1'b1, 5'd1, 1'b0, 1'b1);
        one("jal",      32'h0000006F, 3'b000, 1'b0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b1);
        one("nolsb",    32'h002081B1, 3'b000, 1'b0, 2'b00, 1'b0, 5'd3, 1'b0, 1'b1);

        // Stall for 3 cycles with the next instruction waiting
        out_ready = 1'b0;
        send(32'h002081B3, 32'h200);
        cyc();
        send(32'h402081B3, 32'h204);
        for (int i = 0; i < 3; i++) begin
            check("stall.valid",    out_valid, 1'b1);
            check("stall.in_ready", in_ready, 1'b0);
            check("stall.pc",       out_pc, 32'h200);
            check("stall.sel",      alu_func_sel, 1'b0);
            cyc();
        end
        out_ready = 1'b1;
        #1;
        check("release.in_ready", in_ready, 1'b1);
        cyc();
        in_valid = 1'b0;
        check("release.pc",  out_pc, 32'h204);
        check("release.sel", alu_func_sel, 1'b1);
        cyc();
        check("release.drain", out_valid, 1'b0);

        // Flush during stall with a new instruction offered
        out_ready = 1'b0;
        send(32'h002081B3, 32'h300);
        cyc();
        check("flush.pre", out_valid, 1'b1);
        send(32'h123450B7, 32'h304);
        flush = 1'b1;
        #1;
        check("flush.in_ready", in_ready, 1'b0);
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush.valid", out_valid, 1'b0);
        check("flush.pc",    out_pc, 32'h300);
        check("flush.op1",   op1_sel, 2'b00);
        check("flush.rd_we", rd_we, 1'b0);
        cyc();
        check("flush.stays", out_valid, 1'b0);

        // Reset asserted while a stalled instruction is held
        send(32'h002081B3, 32'h500);
        cyc();
        in_valid = 1'b0;
        check("mrst.pre", out_valid, 1'b1);
        reset_n = 1'b0;
        #1;
        check("mrst.valid", out_valid, 1'b0);
        check("mrst.pc",    out_pc, 32'd0);
        check("mrst.rd_we", rd_we, 1'b0);
        check("mrst.rd",    rd, 5'd0);
        cyc();
        reset_n   = 1'b1;
        out_ready = 1'b1;
        cyc();
        check("mrst.in_ready", in_ready, 1'b1);
        check("mrst.after",    out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
